tpiu_frame_decoder: RTL and testbench
=====================================

// Module: tpiu_frame_decoder
// PURPOSE
//  Consumes the 128-bit TPIU frames that the trace pin interface publishes with a toggling FrAvail flag.
//  The producer runs in the trace clock domain. This block brings each frame into the system clock domain
//  and decodes the TPIU byte/ID multiplexing. It emits a valid/ready byte stream in which every byte is
//  tagged with its 7-bit trace source ID. It feeds the per-ID packet routers.
// PARAMETERS
//  DROP_NULL_ID  1  1: data bytes carrying ID 0x00 are discarded; 0: they are emitted.
//  OVF_BITS      8  Width of the saturating frame-overflow counter.
// PORTS
//  clk          in   1         System clock. Single clock domain for this block.
//  rst          in   1         Asynchronous, active-high reset.
//  FrAvail      in   1         Frame-ready toggle from the trace clock domain (asynchronous to clk).
//  Frame        in   128       Last complete frame, byte n = Frame[127-8n -: 8]; byte 15 is the aux byte.
//  outReady     in   1         Downstream can accept a byte this cycle.
//  outValid     out  1         outByte/outId are valid.
//  outByte      out  8         Decoded trace data byte.
//  outId        out  7         Source ID in force for outByte.
//  frameCount   out  16        Frames accepted; wraps at 0xFFFF->0.
//  ovfCount     out  OVF_BITS  Frames dropped because the holding buffer was full; saturates at all-ones.
// BEHAVIOUR
//  Reset: all outputs are 0. curId=0, pendId invalid. Holding and working buffers are empty. FSM=IDLE.
//   Sync chain flops are 0. Edge detect is disarmed for 3 clk after rst falls; during those cycles
//   lastSample tracks the synchroniser output. No spurious frame is taken, whatever FrAvail's level.
//  CDC: FrAvail passes through 2 flops (s1,s2). newFrame = armed & (s2 != lastSample); lastSample<=s2 every clk.
//   Frame is sampled only when newFrame is high. The producer holds Frame stable for >=1 full frame time
//   after toggling; clk must be at least 4x faster than the frame rate.
//  Buffering: holding reg (hFull) and working reg.
//   newFrame & !hFull -> capture Frame into holding, hFull<=1, frameCount++.
//   newFrame & hFull -> frame is dropped, ovfCount++ (saturating).
//   IDLE & hFull -> the working reg loads, hFull<=0, FSM moves to EMIT.
//   If newFrame coincides with the holding reg emptying, the new frame is captured, not dropped.
//  Latency: FrAvail toggles before clk edge N (sampled into s1 at N).
//   Holding is captured at N+2 and working is loaded at N+3. The first eligible byte has outValid=1 after N+3.
//  EMIT: idx walks positions 0..14 in order. aux = byte15[idx>>1] for even idx.
//   Odd idx: data byte = byte[idx] with ID curId.
//   Even idx, bit0=0: data byte = {byte[7:1], aux}.
//   Even idx, bit0=1: ID change, newId = byte[7:1]; no data output.
//    aux=0: curId<=newId immediately.
//    aux=1: pendId<=newId; it takes effect after byte idx+1 is handled, whether that byte is emitted or dropped.
//    An ID change at idx 14 with aux=1: pendId is applied at end of frame.
//  Position timing:
//   A data position with an output takes >=1 cycle. Hold outValid/outByte/outId stable until outValid&outReady.
//    Advance idx on that edge.
//   Non-output positions (ID change, dropped null-ID byte) take exactly 1 cycle with outValid=0.
//  End of frame: after idx 14 completes, apply any pending ID and return to IDLE.
//   If hFull, a back-to-back load occurs next cycle. Max throughput is 1 byte/clk.
//  curId persists across frames; only reset clears it. Frames are never merged or reordered.
//  ID 0x7F (reserved) is accepted as-is, no special handling.
//  Reset mid-frame: the output is dropped immediately (outValid=0) and any partial frame is lost.
// TESTING
//  1 Frame: byte0=0x07 (ID 3, aux0=0), bytes1..14=0x10..0x1D (even bytes bit0=0), aux=0x00.
//    -> 14 bytes out, id=3; evens emitted as byte&0xFE.
//  2 byte0=0x0B (ID 5), aux bit0=1, curId=3 beforehand.
//    -> byte1 goes out with id=3; byte2 onward go out with id=5.
//  3 Hold outReady=0 for 10 clk mid-frame, then pulse it.
//    -> outByte/outId stay constant while stalled; no byte is lost or duplicated.
//  4 Three FrAvail toggles spaced 20 clk with outReady=0.
//    -> frames 1 and 2 are buffered; frame 3 is dropped. ovfCount=1, frameCount=2.
//  5 Assert rst mid-frame with FrAvail=1 at release; no further toggle.
//    -> outValid stays 0; frameCount stays 0.
//  6 DROP_NULL_ID=1, curId=0 (after reset), frame with no ID change.
//    -> no outValid; the FSM returns to IDLE after 15 clk.

Source files
------------

// File: rtl/tpiu_frame_decoder.sv
// Decodes toggle-flagged 128-bit TPIU frames into an ID-tagged byte stream; first byte valid 3 clk after FrAvail is sampled.
// Backpressure: a stalled output holds the frame, one more frame waits in the holding buffer, and any later frame is counted and dropped.
module tpiu_frame_decoder #(
    parameter int DROP_NULL_ID = 1,
    parameter int OVF_BITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                FrAvail,
    input  logic [127:0]        Frame,
    input  logic                outReady,
    output logic                outValid,
    output logic [7:0]          outByte,
    output logic [6:0]          outId,
    output logic [15:0]         frameCount,
    output logic [OVF_BITS-1:0] ovfCount
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_EMIT = 1'b1;

    logic                s1, s2, lastSample;
    logic [1:0]          armCnt;
    logic                armed, newFrame;

    logic [127:0]        holdFrame, workFrame;
    logic                hFull;
    logic                state;
    logic [3:0]          idx;
    logic [6:0]          curId, pendId;
    logic                pendVld;

    logic [7:0]          frameBytes [0:15];
    logic [7:0]          curByte, auxByte, dataByte;
    logic                auxBit, isIdChange, dropNull, wantOut, posDone, lastPos;
    logic                loadWork, takeFrame, dropFrame;
    logic [6:0]          newId;

    // Edge detection stays disarmed for 3 clk after reset so a FrAvail level held through reset is not seen as a toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            lastSample <= 1'b0;
            armCnt     <= 2'd0;
        end else begin
            s1         <= FrAvail;
            s2         <= s1;
            lastSample <= s2;
            if (armCnt != 2'd3)
                armCnt <= armCnt + 2'd1;
        end
    end

    assign armed    = (armCnt == 2'd3);
    assign newFrame = armed & (s2 ^ lastSample);

    always_comb begin
        for (int i = 0; i < 16; i++)
            frameBytes[i] = workFrame[127 - 8*i -: 8];
    end

    assign curByte    = frameBytes[idx];
    assign auxByte    = workFrame[7:0];
    assign auxBit     = auxByte[idx[3:1]];
    assign isIdChange = ~idx[0] & curByte[0];
    assign newId      = curByte[7:1];
    assign dataByte   = idx[0] ? curByte : {curByte[7:1], auxBit};
    assign dropNull   = (DROP_NULL_ID != 0) && (curId == 7'd0);
    assign wantOut    = (state == STATE_EMIT) && !isIdChange && !dropNull;
    assign posDone    = (state == STATE_EMIT) && (!wantOut || outReady);
    assign lastPos    = (idx == 4'd14);

    // The holding slot frees on the same edge it hands over, so a coincident new frame still fits.
    assign loadWork   = (state == STATE_IDLE) && hFull;
    assign takeFrame  = newFrame && (!hFull || loadWork);
    assign dropFrame  = newFrame && !takeFrame;

    assign outValid   = wantOut;
    assign outByte    = wantOut ? dataByte : 8'd0;
    assign outId      = wantOut ? curId : 7'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdFrame  <= '0;
            hFull      <= 1'b0;
            frameCount <= 16'd0;
            ovfCount   <= '0;
        end else begin
            if (takeFrame) begin
                holdFrame  <= Frame;
                hFull      <= 1'b1;
                frameCount <= frameCount + 16'd1;
            end else if (loadWork) begin
                hFull      <= 1'b0;
            end
            if (dropFrame && (ovfCount != {OVF_BITS{1'b1}}))
                ovfCount <= ovfCount + {{(OVF_BITS-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STATE_IDLE;
            workFrame <= '0;
            idx       <= 4'd0;
            curId     <= 7'd0;
            pendId    <= 7'd0;
            pendVld   <= 1'b0;
        end else if (loadWork) begin
            workFrame <= holdFrame;
            idx       <= 4'd0;
            state     <= STATE_EMIT;
        end else if (posDone) begin
            if (isIdChange) begin
                // A deferred change at the final position has no following byte, so it lands at end of frame.
                if (auxBit && !lastPos) begin
                    pendId  <= newId;
                    pendVld <= 1'b1;
                end else begin
                    curId   <= newId;
                end
            end else if (pendVld) begin
                curId   <= pendId;
                pendVld <= 1'b0;
            end
            if (lastPos)
                state <= STATE_IDLE;
            else
                idx <= idx + 4'd1;
        end
    end

endmodule

// File: tb/tb_tpiu_frame_decoder.sv
// Scoreboard bench for tpiu_frame_decoder: stimulus pushes expected bytes/IDs from a frame-level model, a monitor pops on each handshake.
module tb_tpiu_frame_decoder;

    localparam int OVF_BITS = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                FrAvail;
    logic [127:0]        Frame;
    logic                outReady;
    logic                outValid;
    logic [7:0]          outByte;
    logic [6:0]          outId;
    logic [15:0]         frameCount;
    logic [OVF_BITS-1:0] ovfCount;

    tpiu_frame_decoder #(.DROP_NULL_ID(1), .OVF_BITS(OVF_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .FrAvail    (FrAvail),
        .Frame      (Frame),
        .outReady   (outReady),
        .outValid   (outValid),
        .outByte    (outByte),
        .outId      (outId),
        .frameCount (frameCount),
        .ovfCount   (ovfCount)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         readyMode = 1;
    logic [7:0] expByteQ [$];
    logic [6:0] expIdQ [$];
    logic [6:0] mCurId;
    logic       stallPrev = 1'b0;
    logic [7:0] prevByte;
    logic [6:0] prevId;

    // Frame-level reference: walks the 15 positions applying the byte/ID multiplexing rules.
    task automatic modelFrame(input logic [127:0] f);
        logic [7:0] b [0:15];
        logic       pend;
        logic [6:0] pid;
        logic [7:0] v;
        for (int i = 0; i < 16; i++) b[i] = f[127 - 8*i -: 8];
        pend = 1'b0;
        pid  = 7'd0;
        for (int p = 0; p < 15; p++) begin
            if ((p % 2 == 0) && b[p][0]) begin
                if (b[15][p/2]) begin pend = 1'b1; pid = b[p][7:1]; end
                else mCurId = b[p][7:1];
            end else begin
                v = (p % 2 == 1) ? b[p] : {b[p][7:1], b[15][p/2]};
                if (mCurId != 7'd0) begin
                    expByteQ.push_back(v);
                    expIdQ.push_back(mCurId);
                end
                if (pend) begin mCurId = pid; pend = 1'b0; end
            end
        end
        if (pend) mCurId = pid;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checks++;
                if (!outValid || outByte !== prevByte || outId !== prevId) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b byte=%02h id=%02h, required valid=1 byte=%02h id=%02h",
                             outValid, outByte, outId, prevByte, prevId);
                end
            end
            if (outValid && outReady) begin
                checks++;
                if (expByteQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got byte=%02h id=%02h, required no output", outByte, outId);
                end else begin
                    logic [7:0] eb;
                    logic [6:0] ei;
                    eb = expByteQ.pop_front();
                    ei = expIdQ.pop_front();
                    if (outByte !== eb || outId !== ei) begin
                        errors++;
                        $display("FAIL stream_byte: got byte=%02h id=%02h, required byte=%02h id=%02h",
                                 outByte, outId, eb, ei);
                    end
                end
            end
            stallPrev = outValid && !outReady;
            prevByte  = outByte;
            prevId    = outId;
        end
    end

    initial begin
        outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       outReady = 1'b0;
                1:       outReady = 1'b1;
                default: outReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic sendFrame(input logic [127:0] f, input bit accepted);
        Frame   = f;
        FrAvail = ~FrAvail;
        if (accepted) modelFrame(f);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expByteQ.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        check(name, expByteQ.size(), 0);
        tick(40);
    endtask

    // Byte 0 given, bytes 1..14 random with even positions kept as data, aux byte given.
    function automatic logic [127:0] plainFrame(input logic [7:0] b0, input logic [7:0] aux);
        logic [127:0] f;
        logic [7:0]   b;
        f = '0;
        f[127:120] = b0;
        for (int i = 1; i < 15; i++) begin
            b = 8'($urandom);
            if (i % 2 == 0) b[0] = 1'b0;
            f[127 - 8*i -: 8] = b;
        end
        f[7:0] = aux;
        return f;
    endfunction

    initial begin
        logic [127:0] f, f1, f2, f3;
        logic [15:0]  fc0;
        int           n;

        rst = 1'b1; FrAvail = 1'b0; Frame = '0; mCurId = 7'd0;
        tick(3);
        check("reset_outValid", outValid, 0);
        check("reset_outByte", outByte, 0);
        check("reset_outId", outId, 0);
        check("reset_frameCount", frameCount, 0);
        check("reset_ovfCount", ovfCount, 0);
        rst = 1'b0;
        tick(5);

        // Null ID after reset: every data byte is discarded.
        sendFrame(plainFrame(8'h20, 8'hA5), 1);
        tick(40);
        check("null_frameCount", frameCount, 1);
        check("null_no_output", expByteQ.size(), 0);

        f = '0;
        f[127:120] = 8'h07;
        for (int i = 1; i < 15; i++) begin
            logic [7:0] b;
            b = 8'(8'h10 + i - 1);
            if (i % 2 == 0) b[0] = 1'b0;
            f[127 - 8*i -: 8] = b;
        end
        sendFrame(f, 1);
        check("t1_expected_len", expByteQ.size(), 14);
        waitDrain("t1_drain");
        check("t1_frameCount", frameCount, 2);

        sendFrame(plainFrame(8'h0B, 8'h01), 1);
        waitDrain("t2_deferred_id");

        sendFrame(plainFrame(8'h42, 8'h3C), 1);
        n = 0;
        while (expByteQ.size() > 8 && n < 200) begin tick(1); n++; end
        check("t3_reached_mid", expByteQ.size() <= 8, 1);
        readyMode = 0;
        tick(10);
        readyMode = 1;
        waitDrain("t3_stall_drain");

        readyMode = 0;
        fc0 = frameCount;
        f1 = plainFrame(8'h10, 8'h5A);
        f2 = plainFrame(8'h22, 8'hC3);
        f3 = plainFrame(8'h34, 8'h0F);
        sendFrame(f1, 1); tick(20);
        sendFrame(f2, 1); tick(20);
        sendFrame(f3, 0); tick(20);
        check("t4_frameCount", frameCount, 32'(fc0) + 2);
        check("t4_ovfCount", ovfCount, 1);
        readyMode = 1;
        waitDrain("t4_drain");

        sendFrame(plainFrame(8'hFF, 8'h00), 1);
        waitDrain("reserved_id");

        readyMode = 2;
        for (int k = 0; k < 25; k++) begin
            f = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            sendFrame(f, 1);
            waitDrain("random_drain");
        end
        check("random_ovfCount", ovfCount, 1);

        readyMode = 0;
        sendFrame(plainFrame(8'h07, 8'h00), 1);
        tick(10);
        rst = 1'b1;
        expByteQ.delete();
        expIdQ.delete();
        mCurId = 7'd0;
        FrAvail = 1'b1;
        tick(1);
        check("t5_outValid_in_reset", outValid, 0);
        readyMode = 1;
        tick(2);
        rst = 1'b0;
        tick(30);
        check("t5_frameCount", frameCount, 0);
        check("t5_outValid", outValid, 0);
        check("t5_ovfCount", ovfCount, 0);

        sendFrame(plainFrame(8'h07, 8'h00), 1);
        waitDrain("post_reset_drain");
        check("post_reset_frameCount", frameCount, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
